// File: rtl/mem_pkg.sv
// Shared definitions for the cache/bridge memory subsystem: read types,
// arbiter FSM states and the read request record.
package mem_pkg;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;
  localparam logic [2:0] LINE = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [2:0]  rtype;
    logic [31:0] addr;
  } rd_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// that did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio_last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the bridge's single read/write port between the icache (0) and the
// dcache (1): one outstanding read, round-robin grant, dcache writes pass through.
module cache_mem_arbiter
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           m_rd_req,
  input  logic [1:0][2:0]      m_rd_type,
  input  logic [1:0][31:0]     m_rd_addr,
  output logic [1:0]           m_rd_rdy,
  output logic [1:0]           m_ret_valid,
  output logic [1:0]           m_ret_last,
  output logic [127:0]         m_ret_data,
  input  logic                 d_wr_req,
  input  logic [2:0]           d_wr_type,
  input  logic [31:0]          d_wr_addr,
  input  logic [15:0]          d_wr_wstrb,
  input  logic [127:0]         d_wr_data,
  output logic                 d_wr_rdy,
  output logic                 rd_req,
  output logic [2:0]           rd_type,
  output logic [31:0]          rd_addr,
  input  logic                 rd_rdy,
  input  logic                 ret_valid,
  input  logic                 ret_last,
  input  logic [127:0]         ret_data,
  output logic                 wr_req,
  output logic [2:0]           wr_type,
  output logic [31:0]          wr_addr,
  output logic [15:0]          wr_wstrb,
  output logic [127:0]         wr_data,
  input  logic                 wr_rdy
);

  arb_state_t r_state;
  logic       r_prio_last;
  logic       r_owner;

  logic [1:0] w_grant;
  logic       w_gidx;
  rd_req_t    w_sel;

  rr_arbiter2 u_rr (
    .req       (m_rd_req),
    .prio_last (r_prio_last),
    .grant     (w_grant)
  );

  assign w_gidx = w_grant[1];

  always_comb begin
    w_sel.rtype = m_rd_type[w_gidx];
    w_sel.addr  = m_rd_addr[w_gidx];
  end

  always_comb begin
    rd_req      = 1'b0;
    rd_type     = w_sel.rtype;
    rd_addr     = w_sel.addr;
    m_rd_rdy    = '0;
    m_ret_valid = '0;
    m_ret_last  = '0;
    if (r_state == IDLE) begin
      rd_req   = |w_grant;
      m_rd_rdy = w_grant & {2{rd_rdy}};
    end else begin
      m_ret_valid[r_owner] = ret_valid;
      m_ret_last[r_owner]  = ret_last;
    end
  end

  assign m_ret_data = ret_data;

  assign wr_req   = d_wr_req;
  assign wr_type  = d_wr_type;
  assign wr_addr  = d_wr_addr;
  assign wr_wstrb = d_wr_wstrb;
  assign wr_data  = d_wr_data;
  assign d_wr_rdy = wr_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prio_last <= 1'b0;
      r_owner     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (rd_req && rd_rdy) begin
            r_state     <= w_gidx ? WAIT1 : WAIT0;
            r_prio_last <= w_gidx;
            r_owner     <= w_gidx;
          end
        end
        WAIT0, WAIT1: begin
          if (ret_valid && ret_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A return beat with no read outstanding has no owner and is dropped.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(r_state == IDLE && ret_valid));
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed plus randomized checks of cache_mem_arbiter against a transaction-level
// model: one read in flight, alternating winner on ties, pass-through writes.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           m_rd_req;
  logic [1:0][2:0]      m_rd_type;
  logic [1:0][31:0]     m_rd_addr;
  logic [1:0]           m_rd_rdy;
  logic [1:0]           m_ret_valid;
  logic [1:0]           m_ret_last;
  logic [127:0]         m_ret_data;
  logic                 d_wr_req;
  logic [2:0]           d_wr_type;
  logic [31:0]          d_wr_addr;
  logic [15:0]          d_wr_wstrb;
  logic [127:0]         d_wr_data;
  logic                 d_wr_rdy;
  logic                 rd_req;
  logic [2:0]           rd_type;
  logic [31:0]          rd_addr;
  logic                 rd_rdy;
  logic                 ret_valid;
  logic                 ret_last;
  logic [127:0]         ret_data;
  logic                 wr_req;
  logic [2:0]           wr_type;
  logic [31:0]          wr_addr;
  logic [15:0]          wr_wstrb;
  logic [127:0]         wr_data;
  logic                 wr_rdy;

  cache_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m_rd_req    (m_rd_req),
    .m_rd_type   (m_rd_type),
    .m_rd_addr   (m_rd_addr),
    .m_rd_rdy    (m_rd_rdy),
    .m_ret_valid (m_ret_valid),
    .m_ret_last  (m_ret_last),
    .m_ret_data  (m_ret_data),
    .d_wr_req    (d_wr_req),
    .d_wr_type   (d_wr_type),
    .d_wr_addr   (d_wr_addr),
    .d_wr_wstrb  (d_wr_wstrb),
    .d_wr_data   (d_wr_data),
    .d_wr_rdy    (d_wr_rdy),
    .rd_req      (rd_req),
    .rd_type     (rd_type),
    .rd_addr     (rd_addr),
    .rd_rdy      (rd_rdy),
    .ret_valid   (ret_valid),
    .ret_last    (ret_last),
    .ret_data    (ret_data),
    .wr_req      (wr_req),
    .wr_type     (wr_type),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_data     (wr_data),
    .wr_rdy      (wr_rdy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: is a read in flight, who owns it, who won the last grant.
  bit busy      = 1'b0;
  int owner     = 0;
  int last_win  = 0;
  int n_grants  = 0;
  int grant_log[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] req);
    if (req == 2'b00) return -1;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return 1 - last_win;
  endfunction

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    int g;
    logic [1:0] e_rdy, e_val, e_last;
    #2;
    g = busy ? -1 : pick(m_rd_req);
    e_rdy  = 2'b00;
    e_val  = 2'b00;
    e_last = 2'b00;
    if (g >= 0 && rd_rdy) e_rdy[g] = 1'b1;
    if (busy) begin
      e_val[owner]  = ret_valid;
      e_last[owner] = ret_last;
    end
    chk("rd_req", 128'(rd_req), 128'(g >= 0));
    if (g >= 0) begin
      chk("rd_addr", 128'(rd_addr), 128'(m_rd_addr[g]));
      chk("rd_type", 128'(rd_type), 128'(m_rd_type[g]));
    end
    chk("m_rd_rdy", 128'(m_rd_rdy), 128'(e_rdy));
    chk("m_ret_valid", 128'(m_ret_valid), 128'(e_val));
    chk("m_ret_last", 128'(m_ret_last), 128'(e_last));
    chk("m_ret_data", m_ret_data, ret_data);
    chk("wr_fields", {wr_req, wr_type, wr_addr, wr_wstrb},
        {d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb});
    chk("wr_data", wr_data, d_wr_data);
    chk("d_wr_rdy", 128'(d_wr_rdy), 128'(wr_rdy));
    @(posedge clk);
    if (rst) begin
      busy = 1'b0;
      last_win = 0;
    end else if (g >= 0 && rd_rdy) begin
      busy = 1'b1;
      owner = g;
      last_win = g;
      n_grants++;
      grant_log.push_back(g);
    end else if (busy && ret_valid && ret_last) begin
      busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    m_rd_req  = '0;
    rd_rdy    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    m_rd_type = '0;
    m_rd_addr = '0;
    ret_data  = '0;
    d_wr_req = 1'b0; d_wr_type = '0; d_wr_addr = '0; d_wr_wstrb = '0; d_wr_data = '0;
    wr_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // Single icache line read, one-beat return.
    m_rd_req = 2'b01; m_rd_addr[0] = 32'h1C00_0010; m_rd_type[0] = 3'b100; rd_rdy = 1'b1;
    step();
    quiet();
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = {16{8'hAA}};
    step();
    quiet();
    step();

    // Tie: requester 1 first, then requester 0 after one idle cycle.
    m_rd_req = 2'b11; m_rd_addr[0] = 32'h100; m_rd_addr[1] = 32'h200; rd_rdy = 1'b1;
    step();
    m_rd_req = 2'b01; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 128'h1;
    step();
    ret_valid = 1'b0; ret_last = 1'b0;
    step();
    chk("tie_order", 128'({grant_log[grant_log.size()-2], grant_log[grant_log.size()-1]}),
        128'({32'd1, 32'd0}));
    quiet();
    ret_valid = 1'b1; ret_last = 1'b1;
    step();
    quiet();

    // Requester 0 stalls while requester 1 receives beats.
    m_rd_req = 2'b10; rd_rdy = 1'b1;
    step();
    for (int unsigned i = 0; i < 10; i++) begin
      m_rd_req = 2'b01; rd_rdy = 1'b1;
      ret_valid = i[0]; ret_last = 1'b0; ret_data = 128'(i);
      step();
    end
    ret_valid = 1'b1; ret_last = 1'b1;
    step();
    quiet();

    // Four-beat return to requester 0 with a concurrent dcache write.
    m_rd_req = 2'b01; rd_rdy = 1'b1;
    step();
    quiet();
    d_wr_req = 1'b1; d_wr_addr = 32'h8; d_wr_wstrb = 16'h000F; d_wr_type = 3'b010;
    d_wr_data = 128'hDEAD_BEEF;
    for (int unsigned i = 0; i < 4; i++) begin
      ret_valid = 1'b1; ret_last = (i == 3); ret_data = 128'(i + 32'h50);
      wr_rdy = i[0];
      step();
    end
    quiet();
    d_wr_req = 1'b0; d_wr_addr = '0; d_wr_wstrb = '0; d_wr_type = '0; d_wr_data = '0;
    wr_rdy = 1'b0;
    step();

    // Reset while in WAIT1, then a tie must go to requester 1 again.
    m_rd_req = 2'b10; rd_rdy = 1'b1;
    step();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_rd_req = 2'b11; rd_rdy = 1'b1;
    step();
    chk("tie_after_rst", 128'(grant_log[grant_log.size()-1]), 128'(1));
    quiet();
    ret_valid = 1'b1; ret_last = 1'b1;
    step();
    quiet();

    // Random traffic.
    for (int unsigned i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      m_rd_req     = 2'($urandom);
      m_rd_type[0] = 3'($urandom);
      m_rd_type[1] = 3'($urandom);
      m_rd_addr[0] = $urandom;
      m_rd_addr[1] = $urandom;
      rd_rdy       = 1'($urandom);
      ret_valid    = busy && !rst && ($urandom_range(0, 2) != 0);
      ret_last     = 1'($urandom);
      ret_data     = {$urandom, $urandom, $urandom, $urandom};
      d_wr_req     = 1'($urandom);
      d_wr_type    = 3'($urandom);
      d_wr_addr    = $urandom;
      d_wr_wstrb   = 16'($urandom);
      d_wr_data    = {$urandom, $urandom, $urandom, $urandom};
      wr_rdy       = 1'($urandom);
      step();
    end
    rst = 1'b0;
    quiet();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
